int8_fp16_stream_ctrl: RTL and testbench

- Sequencer that streams packed int8 words through one shared combinational int8tofp16 converter instance and repacks the results as fp16 pairs.
- Each 32-bit input beat carries 4 int8 lanes. The converter is time-multiplexed at one lane per cycle, so each input beat produces two 32-bit output beats.
- Sits between the int8 activation buffer (valid/ready source) and the fp16 vector-unit operand path (valid/ready sink). A start/len command frames each job.

---
 rtl/int8_fp16_stream_ctrl_if.sv | 12 +
 rtl/int8_fp16_stream_ctrl.sv | 153 +++++++++++++++
 tb/tb_int8_fp16_stream_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/int8_fp16_stream_ctrl_if.sv
// Valid/ready stream bundle shared by the int8 input side and the fp16 output side.
// The master drives valid/data and the slave drives ready.
interface int8_fp16_stream_ctrl_if #(
    parameter int W = 32
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/int8_fp16_stream_ctrl.sv
// Streams packed int8 words through one shared int8->fp16 converter, one lane per
// cycle, and repacks the results as fp16 pairs on a valid/ready output.

// Exact int8 -> fp16: sign-magnitude, exponent bias 15, every code representable.
module int8tofp16 (
    input  logic [7:0]  a,
    output logic [15:0] y
);
    logic       sign;
    logic [7:0] mag;
    logic [2:0] msb;
    logic [9:0] mant;

    always_comb begin
        sign = a[7];
        mag  = sign ? (8'd0 - a) : a;
        msb  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (mag[i]) msb = 3'(i);
        end
        // Aligning the leading one to bit 10 leaves the fraction in [9:0].
        mant = 10'({mag, 10'b0} >> msb);
        if (mag == 8'd0) y = 16'h0000;
        else             y = {sign, 5'd15 + {2'b00, msb}, mant};
    end
endmodule

module int8_fp16_stream_ctrl #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] beats_left,
    int8_fp16_stream_ctrl_if.slave  s,
    int8_fp16_stream_ctrl_if.master m
);
    typedef enum logic [1:0] {IDLE, LOAD, CONV, DRAIN} state_t;

    state_t           state_reg,      state_next;
    logic [1:0]       lane_reg,       lane_next;
    logic [31:0]      in_buf_reg,     in_buf_next;
    logic [31:0]      out_pair_reg,   out_pair_next;
    logic             out_full_reg,   out_full_next;
    logic [LEN_W-1:0] beats_left_reg, beats_left_next;
    logic             done_reg,       done_next;

    logic [7:0]  lane_byte [4];
    logic [7:0]  conv_in;
    logic [15:0] conv_out;
    logic        adv;
    logic        take;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_byte[gi] = in_buf_reg[8*gi +: 8];
        end
    endgenerate

    assign conv_in = lane_byte[lane_reg];

    int8tofp16 u_conv (
        .a (conv_in),
        .y (conv_out)
    );

    // A pending pair blocks the converter unless the sink takes it this cycle.
    assign take = out_full_reg & m.ready;
    assign adv  = ~out_full_reg | m.ready;

    always_comb begin
        state_next      = state_reg;
        lane_next       = lane_reg;
        in_buf_next     = in_buf_reg;
        out_pair_next   = out_pair_reg;
        out_full_next   = out_full_reg;
        beats_left_next = beats_left_reg;
        done_next       = 1'b0;

        if (take) out_full_next = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        beats_left_next = len;
                        state_next      = LOAD;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (s.valid) begin
                    in_buf_next = s.data;
                    lane_next   = 2'd0;
                    state_next  = CONV;
                end
            end
            CONV: begin
                if (adv) begin
                    if (lane_reg[0]) out_pair_next[31:16] = conv_out;
                    else             out_pair_next[15:0]  = conv_out;
                    lane_next = lane_reg + 2'd1;
                    // A completed pair re-arms the output even if the old one leaves now.
                    if (lane_reg[0]) out_full_next = 1'b1;
                    if (lane_reg == 2'd3) begin
                        beats_left_next = beats_left_reg - {{(LEN_W-1){1'b0}}, 1'b1};
                        state_next = (beats_left_reg == {{(LEN_W-1){1'b0}}, 1'b1}) ? DRAIN : LOAD;
                    end
                end
            end
            DRAIN: begin
                if (!out_full_reg || m.ready) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            lane_reg       <= 2'd0;
            in_buf_reg     <= 32'd0;
            out_pair_reg   <= 32'd0;
            out_full_reg   <= 1'b0;
            beats_left_reg <= '0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            lane_reg       <= lane_next;
            in_buf_reg     <= in_buf_next;
            out_pair_reg   <= out_pair_next;
            out_full_reg   <= out_full_next;
            beats_left_reg <= beats_left_next;
            done_reg       <= done_next;
        end
    end

    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;
    assign beats_left = beats_left_reg;
    assign s.ready    = (state_reg == LOAD);
    assign m.valid    = out_full_reg;
    assign m.data     = out_pair_reg;
endmodule

// File: tb/tb_int8_fp16_stream_ctrl.sv
// Directed bench for int8_fp16_stream_ctrl: hand-computed fp16 pairs, timing,
// back-pressure, mid-job reset and ignored restarts.
module tb_int8_fp16_stream_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] len;
    logic        busy, done;
    logic [15:0] beats_left;
    logic        s_valid, s_ready, m_valid, m_ready;
    logic [31:0] s_data, m_data;

    int checks = 0;
    int errors = 0;

    int8_fp16_stream_ctrl_if #(.W(32)) s_if ();
    int8_fp16_stream_ctrl_if #(.W(32)) m_if ();

    assign s_if.valid = s_valid;
    assign s_if.data  = s_data;
    assign s_ready    = s_if.ready;
    assign m_valid    = m_if.valid;
    assign m_data     = m_if.data;
    assign m_if.ready = m_ready;

    int8_fp16_stream_ctrl #(.LEN_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .beats_left (beats_left),
        .s          (s_if),
        .m          (m_if)
    );

    always #5 clk = ~clk;

    // Job results recorded by run_job
    logic [31:0] pairs [$];
    int          acc_cyc [$];
    int          done_cyc;
    int          timed_out;
    int          hold_bad;
    int          busy_bad;
    logic [15:0] bl_first;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int n, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3,
                           input int stall, input int restart_at, input int rst_at);
        logic [31:0] words [4];
        logic [31:0] held;
        int idx;
        int cyc;
        int stall_left;
        bit stall_started;
        words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
        idx = 0; stall_left = stall; stall_started = 0; held = 32'd0;
        pairs.delete(); acc_cyc.delete();
        done_cyc = -1; timed_out = 0; hold_bad = 0; busy_bad = 0; bl_first = 16'hxxxx;
        start = 1'b1; len = n[15:0]; s_valid = 1'b0; m_ready = 1'b1;
        step();
        start = 1'b0; len = 16'd0;
        cyc = 1;
        while (done_cyc < 0) begin
            if (cyc > 400) begin
                timed_out = 1;
                break;
            end
            if (cyc == rst_at) begin
                rst = 1'b1; s_valid = 1'b0;
                step();
                rst = 1'b0;
                return;
            end
            if (cyc == 1) bl_first = beats_left;
            if (done) begin
                done_cyc = cyc;
                if (busy) busy_bad++;
                break;
            end
            if (!busy) busy_bad++;
            start   = (cyc == restart_at);
            len     = (cyc == restart_at) ? 16'd7 : 16'd0;
            s_valid = (idx < n);
            s_data  = words[(idx > 3) ? 3 : idx];
            if (!stall_started && m_valid) begin
                stall_started = 1;
                held = m_data;
            end
            m_ready = !(stall_started && stall_left > 0);
            if (stall_started && stall_left > 0) begin
                if (m_data !== held || s_ready) hold_bad++;
                stall_left--;
            end
            if (s_valid && s_ready) begin
                acc_cyc.push_back(cyc);
                idx++;
            end
            if (m_valid && m_ready) pairs.push_back(m_data);
            step();
            cyc++;
        end
        s_valid = 1'b0; start = 1'b0; m_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; len = 16'd0; s_valid = 1'b0; s_data = 32'd0; m_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        checks++;
        if ({busy, done, s_ready, m_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/s_ready/m_valid=%b required 0000", {busy, done, s_ready, m_valid});
        end
        checks++;
        if (m_data !== 32'd0 || beats_left !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: m_data=%h beats_left=%0d required 0/0", m_data, beats_left);
        end
        $display("test_reset: done");
    endtask

    task automatic test_single(input string tag);
        logic [31:0] exp [2];
        exp[0] = 32'hBC003C00; exp[1] = 32'hD80057F0;
        run_job(1, 32'h807FFF01, 32'h0, 32'h0, 32'h0, 0, -1, -1);
        checks++;
        if (timed_out != 0 || pairs.size() != 2) begin
            errors++;
            $display("FAIL %s_count: pairs=%0d timeout=%0d required 2/0", tag, pairs.size(), timed_out);
        end
        for (int i = 0; i < 2 && i < pairs.size(); i++) begin
            checks++;
            if (pairs[i] !== exp[i]) begin
                errors++;
                $display("FAIL %s_pair%0d: got %h required %h", tag, i, pairs[i], exp[i]);
            end
        end
        checks++;
        if (acc_cyc.size() != 1 || acc_cyc[0] != 1 || done_cyc != 7) begin
            errors++;
            $display("FAIL %s_timing: accept=%0d done_cyc=%0d required 1/7", tag,
                     (acc_cyc.size() > 0) ? acc_cyc[0] : -1, done_cyc);
        end
        checks++;
        if (bl_first !== 16'd1 || beats_left !== 16'd0 || busy_bad != 0) begin
            errors++;
            $display("FAIL %s_beats: first=%0d last=%0d busy_bad=%0d required 1/0/0", tag,
                     bl_first, beats_left, busy_bad);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: done=%b required 0", tag, done);
        end
        $display("test_single(%s): pairs=%0d done_cyc=%0d", tag, pairs.size(), done_cyc);
    endtask

    task automatic test_zero_len();
        int bad;
        start = 1'b1; len = 16'd0;
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_done: done=%b busy=%b required 1/0", done, busy);
        end
        bad = 0;
        s_valid = 1'b1; s_data = 32'h12345678;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done || busy || s_ready || m_valid) bad++;
        end
        s_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL zero_len_quiet: activity_cycles=%0d required 0", bad);
        end
        $display("test_zero_len: done");
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [6];
        exp[0] = 32'h56400000; exp[1] = 32'h4000C000; exp[2] = 32'h00000000;
        exp[3] = 32'h00000000; exp[4] = 32'hD8003C00; exp[5] = 32'h57F057F0;
        run_job(3, 32'h02FE6400, 32'h00000000, 32'h7F7F8001, 32'h0, 0, -1, -1);
        checks++;
        if (timed_out != 0 || pairs.size() != 6) begin
            errors++;
            $display("FAIL b2b_count: pairs=%0d timeout=%0d required 6/0", pairs.size(), timed_out);
        end
        for (int i = 0; i < 6 && i < pairs.size(); i++) begin
            checks++;
            if (pairs[i] !== exp[i]) begin
                errors++;
                $display("FAIL b2b_pair%0d: got %h required %h", i, pairs[i], exp[i]);
            end
        end
        checks++;
        if (acc_cyc.size() != 3 || acc_cyc[0] != 1 || acc_cyc[1] != 6 || acc_cyc[2] != 11 || done_cyc != 17) begin
            errors++;
            $display("FAIL b2b_rate: accepts=%0d done_cyc=%0d required 1,6,11/17", acc_cyc.size(), done_cyc);
        end
        $display("test_back_to_back: pairs=%0d done_cyc=%0d", pairs.size(), done_cyc);
    endtask

    task automatic test_backpressure();
        logic [31:0] exp [4];
        exp[0] = 32'hBC003C00; exp[1] = 32'hD80057F0; exp[2] = 32'h56400000; exp[3] = 32'h4000C000;
        run_job(2, 32'h807FFF01, 32'h02FE6400, 32'h0, 32'h0, 10, -1, -1);
        checks++;
        if (timed_out != 0 || pairs.size() != 4 || hold_bad != 0) begin
            errors++;
            $display("FAIL stall_hold: pairs=%0d hold_bad=%0d timeout=%0d required 4/0/0",
                     pairs.size(), hold_bad, timed_out);
        end
        for (int i = 0; i < 4 && i < pairs.size(); i++) begin
            checks++;
            if (pairs[i] !== exp[i]) begin
                errors++;
                $display("FAIL stall_pair%0d: got %h required %h", i, pairs[i], exp[i]);
            end
        end
        $display("test_backpressure: pairs=%0d done_cyc=%0d", pairs.size(), done_cyc);
    endtask

    task automatic test_mid_reset();
        int bad;
        run_job(4, 32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404, 0, -1, 3);
        checks++;
        if ({busy, done, s_ready, m_valid} !== 4'b0000 || m_data !== 32'd0 || beats_left !== 16'd0) begin
            errors++;
            $display("FAIL midrst_state: ctrl=%b m_data=%h beats_left=%0d required 0000/0/0",
                     {busy, done, s_ready, m_valid}, m_data, beats_left);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done || busy || m_valid) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midrst_nodone: activity_cycles=%0d required 0", bad);
        end
        $display("test_mid_reset: done");
        test_single("after_rst");
    endtask

    task automatic test_ignored_start();
        int bad;
        run_job(2, 32'h807FFF01, 32'h02FE6400, 32'h0, 32'h0, 0, 3, -1);
        checks++;
        if (timed_out != 0 || pairs.size() != 4 || acc_cyc.size() != 2 || done_cyc != 12) begin
            errors++;
            $display("FAIL restart_ignored: pairs=%0d accepts=%0d done_cyc=%0d required 4/2/12",
                     pairs.size(), acc_cyc.size(), done_cyc);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (busy || s_ready) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL restart_idle: active_cycles=%0d required 0", bad);
        end
        $display("test_ignored_start: pairs=%0d done_cyc=%0d", pairs.size(), done_cyc);
    endtask

    initial begin
        test_reset();
        test_single("single");
        test_zero_len();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_ignored_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
